// File: rtl/sa_host_pkg.sv
// Shared definitions for the systolic-array host endpoint: FSM encoding
// and tile-geometry helpers used to size frames and index counters.
package sa_host_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_IN = 3'd1,
    GAP     = 3'd2,
    SEND_W  = 3'd3,
    RECV    = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Elements per frame for a p x q tile.
  function automatic int sa_n(input int p, input int q);
    return p * q;
  endfunction

  // Index width for an n-element frame (at least one bit).
  function automatic int sa_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_buf_tx.sv
// Buffer-indexed AXI-Stream frame transmitter. While active it presents
// src_data (the buffer element at idx) as a beat, advances idx only on a
// handshake and raises tlast on element N-1. idx wraps to 0 after the last
// beat so the next frame always starts from element 0.
module axis_buf_tx #(
  parameter int DW = 8,
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic [DW-1:0] src_data,
  input  logic          tready,
  output logic [AW-1:0] idx,
  output logic [DW-1:0] tdata,
  output logic          tvalid,
  output logic          tlast,
  output logic          last_hs
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic hs;

  // Beat presentation; tdata is gated to zero whenever no beat is offered.
  always_comb begin
    tvalid  = active;
    tlast   = active && (idx == LAST_IDX);
    tdata   = active ? src_data : '0;
    hs      = active && tready;
    last_hs = hs && (idx == LAST_IDX);
  end

  // Element index: holds during stalls, wraps to 0 after the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (hs) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + AW'(1);
    end
  end

endmodule

// File: rtl/axis_sa_host.sv
// Host-side AXI-Stream endpoint for the systolic-array tile wrapper.
// Holds an input tile and a weight tile written through a simple port,
// streams them as framed AXIS beats and captures the result frame into a
// readable buffer.
//
// Handshake rule for both AXIS sides: a beat transfers on a rising clock
// edge where tvalid and tready are both high; the master keeps tdata,
// tvalid and tlast stable until that edge.
module axis_sa_host
  import sa_host_pkg::*;
#(
  parameter int DW = 8,
  parameter int OW = 16,
  parameter int P  = 8,
  parameter int Q  = 8,
  localparam int N  = sa_n(P, Q),
  localparam int AW = sa_aw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          send_weight,
  input  logic          buf_we,
  input  logic          buf_sel,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_wdata,
  input  logic [AW-1:0] res_addr,
  output logic [OW-1:0] res_rdata,
  output logic          busy,
  output logic          done,
  output logic          frame_err,
  output logic          load_control,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  input  logic [OW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [2:0]    dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] in_mem  [N];
  logic [DW-1:0] w_mem   [N];
  logic [OW-1:0] res_mem [N];
  logic [AW-1:0] tx_idx;
  logic [DW-1:0] src_data;
  logic          tx_active;
  logic          tx_last_hs;
  logic [AW-1:0] rx_k;
  logic          s_hs;
  logic          rx_at_last;
  logic          rx_end;
  logic          start_ok;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    done          = (state == DONE);
    s_axis_tready = (state == RECV);
    tx_active     = (state == SEND_IN) || (state == SEND_W);
    start_ok      = (state == IDLE) && start;
    s_hs          = (state == RECV) && s_axis_tvalid;
    rx_at_last    = (rx_k == LAST_IDX);
    rx_end        = s_hs && (s_axis_tlast || rx_at_last);
    dbg_state     = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND_IN;
      SEND_IN: if (tx_last_hs) state_nxt = load_control ? GAP : RECV;
      GAP:     state_nxt = SEND_W;
      SEND_W:  if (tx_last_hs) state_nxt = RECV;
      RECV:    if (rx_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Transaction control: latched mode, sticky framing error, result index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_control <= 1'b0;
      frame_err    <= 1'b0;
      rx_k         <= '0;
    end else if (start_ok) begin
      load_control <= send_weight;
      frame_err    <= 1'b0;
      rx_k         <= '0;
    end else if (s_hs) begin
      if (s_axis_tlast != rx_at_last) frame_err <= 1'b1;
      rx_k <= rx_end ? '0 : rx_k + AW'(1);
    end
  end

  // Tile buffer writes, only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (buf_we && (state == IDLE)) begin
      if (buf_sel) w_mem[buf_addr]  <= buf_wdata;
      else         in_mem[buf_addr] <= buf_wdata;
    end
  end

  // Result capture; contents survive reset.
  always_ff @(posedge clk) begin
    if (s_hs) res_mem[rx_k] <= s_axis_tdata;
  end

  // Registered result read port (same-cycle write returns old data).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_rdata <= '0;
    else        res_rdata <= res_mem[res_addr];
  end

  // Transmit source follows the frame currently being sent.
  always_comb begin
    src_data = (state == SEND_W) ? w_mem[tx_idx] : in_mem[tx_idx];
  end

  axis_buf_tx #(
    .DW (DW),
    .N  (N),
    .AW (AW)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (tx_active),
    .src_data (src_data),
    .tready   (m_axis_tready),
    .idx      (tx_idx),
    .tdata    (m_axis_tdata),
    .tvalid   (m_axis_tvalid),
    .tlast    (m_axis_tlast),
    .last_hs  (tx_last_hs)
  );

endmodule

// File: tb/tb_axis_sa_host.sv
// Self-checking bench for axis_sa_host on a 2x2 tile (N = 4).
module tb_axis_sa_host;

  localparam int DW = 8;
  localparam int OW = 16;
  localparam int P  = 2;
  localparam int Q  = 2;
  localparam int AW = 2;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          send_weight = 1'b0;
  logic          buf_we = 1'b0;
  logic          buf_sel = 1'b0;
  logic [AW-1:0] buf_addr = '0;
  logic [DW-1:0] buf_wdata = '0;
  logic [AW-1:0] res_addr = '0;
  logic [OW-1:0] res_rdata;
  logic          busy, done, frame_err, load_control;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic [OW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  axis_sa_host #(.DW(DW), .OW(OW), .P(P), .Q(Q)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .send_weight   (send_weight),
    .buf_we        (buf_we),
    .buf_sel       (buf_sel),
    .buf_addr      (buf_addr),
    .buf_wdata     (buf_wdata),
    .res_addr      (res_addr),
    .res_rdata     (res_rdata),
    .busy          (busy),
    .done          (done),
    .frame_err     (frame_err),
    .load_control  (load_control),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          tready;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] feed_q[$];
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic r, input logic v, input logic [DW-1:0] d, input logic l);
    vec_t e;
    e.tready = r;
    e.tvalid = v;
    e.tdata  = d;
    e.tlast  = l;
    vecs.push_back(e);
  endtask

  task automatic write_buf(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    buf_we    = 1'b1;
    buf_sel   = sel;
    buf_addr  = addr;
    buf_wdata = data;
    @(negedge clk);
    buf_we    = 1'b0;
  endtask

  // Pulse start; on return the first beat is visible.
  task automatic start_tx(input logic sw);
    start       = 1'b1;
    send_weight = sw;
    @(negedge clk);
    start       = 1'b0;
    send_weight = 1'b0;
    check("busy_after_start", busy, 1);
    check("load_control_latched", load_control, sw);
  endtask

  // Apply the per-cycle master-side vector table, one row per cycle.
  task automatic run_vecs(input string tag, input logic exp_lc);
    foreach (vecs[i]) begin
      m_tready = vecs[i].tready;
      check($sformatf("%s_tvalid[%0d]", tag, i), m_tvalid, vecs[i].tvalid);
      check($sformatf("%s_tdata[%0d]", tag, i), m_tdata, vecs[i].tdata);
      check($sformatf("%s_tlast[%0d]", tag, i), m_tlast, vecs[i].tlast);
      check($sformatf("%s_load_control[%0d]", tag, i), load_control, exp_lc);
      @(negedge clk);
    end
    m_tready = 1'b0;
    vecs.delete();
  endtask

  // Feed nbeats results from feed_q, tlast on beat last_at (-1 = never).
  task automatic feed_results(input string tag, input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = feed_q[i];
      s_tlast  = (i == last_at);
      check($sformatf("%s_s_tready[%0d]", tag, i), s_tready, 1);
      check($sformatf("%s_no_early_done[%0d]", tag, i), done, 0);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_busy_in_done"}, busy, 1);
    check({tag, "_s_tready_in_done"}, s_tready, 0);
    @(negedge clk);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_state_idle"}, dbg_state, 0);
    feed_q.delete();
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] addr);
    logic [OW-1:0] e;
    e = exp_q.pop_front();
    res_addr = addr;
    @(negedge clk);
    check($sformatf("%s_res[%0d]", tag, addr), res_rdata, e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load_control"}, load_control, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_res_rdata"}, res_rdata, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic std_input_frame(input logic [DW-1:0] b0);
    add_vec(1, 1, b0, 0);
    add_vec(1, 1, 2, 0);
    add_vec(1, 1, 3, 0);
    add_vec(1, 1, 4, 1);
    add_vec(0, 0, 0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) write_buf(1'b0, AW'(i), DW'(i + 1));
    for (int i = 0; i < 4; i++) write_buf(1'b1, AW'(i), DW'(i + 5));

    // Input frame only, no backpressure.
    start_tx(1'b0);
    std_input_frame(8'd1);
    run_vecs("t1", 1'b0);
    feed_q = '{16'd10, 16'd20, 16'd30, 16'd40};
    feed_results("t1", 4, 3);
    check("t1_frame_err", frame_err, 0);
    exp_q = '{16'd10, 16'd20, 16'd30, 16'd40};
    for (int i = 0; i < 4; i++) read_check("t1", AW'(i));

    // Input frame, one-cycle gap, weight frame.
    start_tx(1'b1);
    add_vec(1, 1, 1, 0); add_vec(1, 1, 2, 0); add_vec(1, 1, 3, 0); add_vec(1, 1, 4, 1);
    add_vec(1, 0, 0, 0);
    add_vec(1, 1, 5, 0); add_vec(1, 1, 6, 0); add_vec(1, 1, 7, 0); add_vec(1, 1, 8, 1);
    add_vec(0, 0, 0, 0);
    run_vecs("t2", 1'b1);
    check("t2_s_tready_recv", s_tready, 1);
    feed_q = '{16'd100, 16'd200, 16'd300, 16'd400};
    feed_results("t2", 4, 3);
    check("t2_frame_err", frame_err, 0);

    // Backpressure: tready 1,0,0,1,... beats hold steady while stalled.
    start_tx(1'b0);
    add_vec(1, 1, 1, 0);
    add_vec(0, 1, 2, 0); add_vec(0, 1, 2, 0); add_vec(1, 1, 2, 0);
    add_vec(0, 1, 3, 0); add_vec(0, 1, 3, 0); add_vec(1, 1, 3, 0);
    add_vec(0, 1, 4, 1); add_vec(0, 1, 4, 1); add_vec(1, 1, 4, 1);
    add_vec(0, 0, 0, 0);
    run_vecs("t3", 1'b0);
    feed_q = '{16'd31, 16'd32, 16'd33, 16'd34};
    feed_results("t3", 4, 3);
    check("t3_frame_err", frame_err, 0);

    // Short result frame: tlast on the second beat.
    start_tx(1'b0);
    std_input_frame(8'd1);
    run_vecs("t4", 1'b0);
    feed_q = '{16'h0707, 16'h0909};
    feed_results("t4", 2, 1);
    check("t4_frame_err_set", frame_err, 1);
    exp_q = '{16'h0707, 16'h0909, 16'd33, 16'd34};
    for (int i = 0; i < 4; i++) read_check("t4", AW'(i));

    // Next start clears the error; then a full frame missing tlast.
    start_tx(1'b0);
    check("t5_frame_err_cleared", frame_err, 0);
    std_input_frame(8'd1);
    run_vecs("t5", 1'b0);
    feed_q = '{16'd51, 16'd52, 16'd53, 16'd54};
    feed_results("t5", 4, -1);
    check("t5_frame_err_no_tlast", frame_err, 1);

    // Reset after two input beats.
    start_tx(1'b0);
    m_tready = 1'b1;
    check("t6_beat0", m_tdata, 1);
    @(negedge clk);
    check("t6_beat1", m_tdata, 2);
    @(negedge clk);
    m_tready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write in the start cycle lands before beat 0 is read; frame restarts at 0.
    start = 1'b1;
    buf_we = 1'b1;
    buf_sel = 1'b0;
    buf_addr = 2'd0;
    buf_wdata = 8'h11;
    @(negedge clk);
    start = 1'b0;
    buf_we = 1'b0;
    std_input_frame(8'h11);
    run_vecs("t7", 1'b0);
    // Write and start while busy must be ignored.
    start = 1'b1;
    buf_we = 1'b1;
    buf_addr = 2'd1;
    buf_wdata = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    buf_we = 1'b0;
    check("t7_state_still_recv", dbg_state, 4);
    feed_q = '{16'd71, 16'd72, 16'd73, 16'd74};
    feed_results("t7", 4, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("t7_no_restart_busy[%0d]", i), busy, 0);
      check($sformatf("t7_no_restart_tvalid[%0d]", i), m_tvalid, 0);
    end

    // Buffer element 1 must still hold its original value.
    start_tx(1'b0);
    std_input_frame(8'h11);
    run_vecs("t8", 1'b0);
    feed_q = '{16'd81, 16'd82, 16'd83, 16'd84};
    feed_results("t8", 4, 3);
    exp_q = '{16'd81, 16'd84};
    read_check("t8", 2'd0);
    read_check("t8", 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
